sfr_bus_arbiter: RTL and testbench
==================================

Name: sfr_bus_arbiter

Overview:
- Shares the single 8-bit SFR access port (addr / write_val / write_valid / read_val) between two requesters: port 0 = CPU core, port 1 = debug/loader host.
- Sequences every access as setup -> strobe -> hold, so the SFR's edge-triggered write latch always sees stable address and data.
- Holds writes to the serial-out address range while the UART transmitter is busy, with a timeout.
- Sits between the requesters and the SFR block; it is the only driver of the SFR port.

Parameters:
- STROBE_LEN, 1, cycles sfr_write_valid is held high per write; legal range 1..15.
- SOUT_ADDR, 10, lowest SFR address routed to the serial output; writes with addr >= SOUT_ADDR are subject to tx_busy gating.
- TX_TIMEOUT, 1023, max cycles a write waits on tx_busy before it is dropped; 0 = wait forever; legal range 0..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req0, req1  in  1  access request; held until the matching ack
- we0, we1  in  1  1 = write, 0 = read; sampled at grant
- addr0, addr1  in  8  SFR address; sampled at grant
- wdata0, wdata1  in  8  write data; sampled at grant
- ack0, ack1  out  1  one-cycle completion pulse
- rdata  out  8  read result; valid in the ack cycle, held until the next ack
- err  out  1  valid with ack; 1 = write dropped by TX_TIMEOUT
- sfr_addr  out  8  to SFR addr
- sfr_write_val  out  8  to SFR write_val
- sfr_write_valid  out  1  to SFR write_valid
- sfr_read_val  in  8  from SFR read_val (combinational)
- tx_busy  in  1  serial transmitter busy

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - All outputs 0: sfr_write_valid drops at once, including mid-strobe.
  - last_grant = 1, so port 0 wins the first tie.
  - Counters cleared; any in-flight access is abandoned with no ack.
- IDLE:
  - sfr_addr = 0 (NOP address), sfr_write_val = 0, sfr_write_valid = 0.
  - If any req is high, grant it and latch its we/addr/wdata into internal regs; go to SETUP next cycle.
  - Both high: grant the port != last_grant (round robin). Single request: grant it.
- SETUP (1 cycle): drive sfr_addr/sfr_write_val from the latched regs.
  - Read: go to SAMPLE.
  - Write with addr >= SOUT_ADDR and tx_busy = 1: go to WAIT_TX.
  - Otherwise: go to STROBE.
- WAIT_TX: addr/data held, sfr_write_valid = 0, wait counter increments each cycle.
  - tx_busy = 0: go to STROBE.
  - TX_TIMEOUT != 0 and counter reaches TX_TIMEOUT: go to DONE with err = 1; no strobe is issued.
  - tx_busy = 0 and timeout in the same cycle: tx_busy wins, go to STROBE.
- STROBE: sfr_write_valid = 1 for exactly STROBE_LEN cycles, addr/data stable; then HOLD.
- HOLD (1 cycle): sfr_write_valid = 0, addr/data still held; then DONE.
- SAMPLE (1 cycle): rdata <= sfr_read_val; then DONE.
- DONE (1 cycle):
  - ack of the granted port = 1, err as decided, last_grant <= granted port.
  - sfr_addr/sfr_write_val keep the latched values; go to IDLE.
- Latency, counted from the IDLE cycle in which req is sampled:
  - Read: ack at cycle +3.
  - Write (no wait): ack at cycle +3+STROBE_LEN.
- Request rules:
  - A requester must drop req in its ack cycle. A req still high in the following IDLE is a new access.
  - Requests arriving mid-access wait; no queuing beyond the req level.
  - Request inputs change only at grant; changes during an access are ignored.
- Exactly one sfr_write_valid rising edge per non-dropped write; none for reads or dropped writes.
- Addresses are not range-checked. Out-of-range reads return whatever sfr_read_val gives; addresses >= SOUT_ADDR are serial writes.

Test Plan:
- Reset, then req0 write addr 5 data 0x3C, STROBE_LEN = 1:
  - Expect SETUP with sfr_addr = 5 / sfr_write_val = 0x3C one cycle before sfr_write_valid.
  - Expect a 1-cycle strobe, then a hold cycle, ack0 at +4, err = 0.
- req0 and req1 reads asserted in the same cycle (addr 1 and 2, sfr_read_val driven as addr+0x40):
  - Expect port 0 served first, ack0 at +3 with rdata = 0x41.
  - Port 1 is then granted in the next IDLE and acks with rdata = 0x42.
- Continuous req0 plus a req1 raised during port 0's access: grants alternate 0,1,0,1; neither port is starved.
- Write addr 10 data 0x48 with tx_busy high for 20 cycles, TX_TIMEOUT = 1023: expect WAIT_TX for 20 cycles, then one strobe, ack with err = 0.
- Same write with TX_TIMEOUT = 8 and tx_busy stuck high: expect no sfr_write_valid edge; ack with err = 1 at +2+8+1 cycles.
- Assert rst during STROBE with STROBE_LEN = 4:
  - Expect sfr_write_valid low in the same cycle, no ack, outputs 0.
  - After release, a req1 write completes normally and port 0 wins the next tie.

Source files
------------

// File: rtl/sfr_bus_arbiter.sv
// Two-port arbiter for the 8-bit SFR access port.
// Each access runs setup -> strobe -> hold, and serial-out writes wait on tx_busy with a timeout.
`timescale 1ns/1ps
module sfr_bus_arbiter #(
  parameter int unsigned STROBE_LEN = 1,
  parameter int unsigned SOUT_ADDR  = 10,
  parameter int unsigned TX_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       err,
  output logic [7:0] sfr_addr,
  output logic [7:0] sfr_write_val,
  output logic       sfr_write_valid,
  input  logic [7:0] sfr_read_val,
  input  logic       tx_busy
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAIT_TX, S_STROBE, S_HOLD, S_SAMPLE, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wval_q, wval_d;
  logic          wv_q, wv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wval_d  = wval_q;
    wv_d    = 1'b0;
    cnt_d   = cnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        wval_d = '0;
        if (req0 || req1) begin
          // Tie goes to the port that was not served last
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          we_d    = gnt_d ? we1 : we0;
          addr_d  = gnt_d ? addr1 : addr0;
          wval_d  = gnt_d ? wdata1 : wdata0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d = '0;
        if (!we_q) begin
          state_d = S_SAMPLE;
        end else if ((addr_q >= AW'(SOUT_ADDR)) && tx_busy) begin
          state_d = S_WAIT_TX;
        end else begin
          state_d = S_STROBE;
          wv_d    = 1'b1;
        end
      end
      S_WAIT_TX: begin
        if (!tx_busy) begin
          state_d = S_STROBE;
          wv_d    = 1'b1;
          cnt_d   = '0;
        end else if ((TX_TIMEOUT != 0) && (cnt_q == CW'(TX_TIMEOUT))) begin
          state_d = S_DONE;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == CW'(STROBE_LEN - 1)) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
          wv_d  = 1'b1;
        end
      end
      S_HOLD: begin
        state_d = S_DONE;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
      end
      S_SAMPLE: begin
        rdata_d = sfr_read_val;
        state_d = S_DONE;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
        addr_d  = '0;
        wval_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        wval_d  = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any access at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wval_q  <= '0;
      wv_q    <= 1'b0;
      cnt_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wval_q  <= wval_d;
      wv_q    <= wv_d;
      cnt_q   <= cnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack0            = ack0_q;
  assign ack1            = ack1_q;
  assign err             = err_q;
  assign rdata           = rdata_q;
  assign sfr_addr        = addr_q;
  assign sfr_write_val   = wval_q;
  assign sfr_write_valid = wv_q;

endmodule

// File: tb/tb_sfr_bus_arbiter.sv
// Directed bench for sfr_bus_arbiter: three instances (default, short timeout, 4-cycle strobe)
// share the requester inputs; every scenario starts from reset.
`timescale 1ns/1ps
module tb_sfr_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, tx_busy = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic       d_ack0, d_ack1, d_err, d_wv;
  logic [7:0] d_rdata, d_addr, d_wval, d_rv;
  logic       t_ack0, t_ack1, t_err, t_wv;
  logic [7:0] t_rdata, t_addr, t_wval, t_rv;
  logic       s_ack0, s_ack1, s_err, s_wv;
  logic [7:0] s_rdata, s_addr, s_wval, s_rv;

  int n_tests = 0;
  int n_fail  = 0;
  int d_edges = 0, t_edges = 0, s_edges = 0;
  logic d_wv_p = 1'b0, t_wv_p = 1'b0, s_wv_p = 1'b0;

  always #5 clk = ~clk;

  assign d_rv = d_addr + 8'h40;
  assign t_rv = t_addr + 8'h40;
  assign s_rv = s_addr + 8'h40;

  sfr_bus_arbiter u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(d_ack0), .ack1(d_ack1), .rdata(d_rdata), .err(d_err),
    .sfr_addr(d_addr), .sfr_write_val(d_wval), .sfr_write_valid(d_wv),
    .sfr_read_val(d_rv), .tx_busy(tx_busy)
  );

  sfr_bus_arbiter #(.TX_TIMEOUT(8)) u_to (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(t_ack0), .ack1(t_ack1), .rdata(t_rdata), .err(t_err),
    .sfr_addr(t_addr), .sfr_write_val(t_wval), .sfr_write_valid(t_wv),
    .sfr_read_val(t_rv), .tx_busy(tx_busy)
  );

  sfr_bus_arbiter #(.STROBE_LEN(4)) u_sl4 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(s_ack0), .ack1(s_ack1), .rdata(s_rdata), .err(s_err),
    .sfr_addr(s_addr), .sfr_write_val(s_wval), .sfr_write_valid(s_wv),
    .sfr_read_val(s_rv), .tx_busy(tx_busy)
  );

  // Rising edges of each strobe
  always @(negedge clk) begin
    if (d_wv && !d_wv_p) d_edges++;
    if (t_wv && !t_wv_p) t_edges++;
    if (s_wv && !s_wv_p) s_edges++;
    d_wv_p = d_wv;
    t_wv_p = t_wv;
    s_wv_p = s_wv;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; tx_busy = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [27:0] obs;
    rst = 1'b1;
    tick();
    obs = {d_ack0, d_ack1, d_err, d_wv, d_addr, d_wval, d_rdata};
    n_tests++;
    if (obs !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_basic();
    int e0;
    do_reset();
    e0 = d_edges;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 8'h3C;
    tick();
    n_tests++;
    if ({d_addr, d_wval, d_wv} !== {8'd5, 8'h3C, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_setup: got addr=%h val=%h wv=%b expected 05 3c 0", d_addr, d_wval, d_wv);
    end
    tick();
    n_tests++;
    if ({d_addr, d_wval, d_wv} !== {8'd5, 8'h3C, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_strobe: got addr=%h val=%h wv=%b expected 05 3c 1", d_addr, d_wval, d_wv);
    end
    tick();
    n_tests++;
    if ({d_addr, d_wv, d_ack0} !== {8'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_hold: got addr=%h wv=%b ack0=%b expected 05 0 0", d_addr, d_wv, d_ack0);
    end
    tick();
    n_tests++;
    if ({d_ack0, d_ack1, d_err, d_addr} !== {3'b100, 8'd5}) begin
      n_fail++;
      $display("FAIL wr_ack: got ack0=%b ack1=%b err=%b addr=%h expected 1 0 0 05",
               d_ack0, d_ack1, d_err, d_addr);
    end
    req0 = 1'b0;
    tick();
    n_tests++;
    if ({d_ack0, d_addr, (d_edges - e0) == 1} !== {1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_idle: got ack0=%b addr=%h edges=%0d expected 0 00 1",
               d_ack0, d_addr, d_edges - e0);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd2;
    tick(); tick(); tick();
    n_tests++;
    if ({d_ack0, d_ack1, d_rdata} !== {2'b10, 8'h41}) begin
      n_fail++;
      $display("FAIL arb_first: got ack0=%b ack1=%b rdata=%h expected 1 0 41", d_ack0, d_ack1, d_rdata);
    end
    req0 = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if ({d_ack0, d_ack1, d_rdata} !== {2'b00, 8'h41}) begin
      n_fail++;
      $display("FAIL arb_rdata_held: got ack0=%b ack1=%b rdata=%h expected 0 0 41", d_ack0, d_ack1, d_rdata);
    end
    tick();
    n_tests++;
    if ({d_ack0, d_ack1, d_rdata} !== {2'b01, 8'h42}) begin
      n_fail++;
      $display("FAIL arb_second: got ack0=%b ack1=%b rdata=%h expected 0 1 42", d_ack0, d_ack1, d_rdata);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int got;
    int exp_port;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1;
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd2;
    for (int k = 0; k < 4; k++) begin
      exp_port = k % 2;
      got = -1;
      for (int c = 0; c < 20 && got < 0; c++) begin
        tick();
        if (d_ack0) got = 0;
        else if (d_ack1) got = 1;
      end
      n_tests++;
      if (got != exp_port || d_rdata !== (exp_port == 1 ? 8'h42 : 8'h41)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got port=%0d rdata=%h expected port=%0d", k, got, d_rdata, exp_port);
      end
      // Drop in the ack cycle, raise again in the next IDLE so both ports contend
      if (got == 0) req0 = 1'b0;
      if (got == 1) req1 = 1'b0;
      tick();
      if (got == 0) req0 = 1'b1;
      if (got == 1) req1 = 1'b1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_tx_wait();
    int e0;
    logic early;
    do_reset();
    e0 = d_edges;
    early = 1'b0;
    tx_busy = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd10; wdata0 = 8'h48;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (d_wv || d_ack0 || d_addr !== 8'd10) early = 1'b1;
    end
    n_tests++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_wait_hold: got early strobe/ack/addr change expected none");
    end
    tx_busy = 1'b0;
    tick();
    n_tests++;
    if (d_wv !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_wait_strobe: got wv=%b expected 1", d_wv);
    end
    tick(); tick();
    n_tests++;
    if ({d_ack0, d_err, (d_edges - e0) == 1} !== 3'b101) begin
      n_fail++;
      $display("FAIL tx_wait_ack: got ack0=%b err=%b edges=%0d expected 1 0 1", d_ack0, d_err, d_edges - e0);
    end
    req0 = 1'b0;
    tick();
    // Address just below the serial range is not gated by tx_busy
    tx_busy = 1'b1;
    req0 = 1'b1; addr0 = 8'd9; wdata0 = 8'h55;
    tick(); tick(); tick(); tick();
    n_tests++;
    if ({d_ack0, d_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL tx_below_range: got ack0=%b err=%b expected 1 0", d_ack0, d_err);
    end
    req0 = 1'b0;
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic test_tx_timeout();
    int e0;
    int lat;
    do_reset();
    e0 = t_edges;
    tx_busy = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd10; wdata0 = 8'h48;
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      if (t_ack0) lat = c;
    end
    n_tests++;
    if (lat != 11 || t_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_timeout_ack: got latency=%0d err=%b expected 11 1", lat, t_err);
    end
    n_tests++;
    if (t_edges != e0) begin
      n_fail++;
      $display("FAIL tx_timeout_nostrobe: got %0d strobe edges expected 0", t_edges - e0);
    end
    req0 = 1'b0;
    tick();
    n_tests++;
    if ({t_ack0, t_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL tx_timeout_clear: got ack0=%b err=%b expected 0 0", t_ack0, t_err);
    end
    tx_busy = 1'b0;
  endtask

  task automatic test_reset_mid_strobe();
    logic seen_ack;
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd3; wdata0 = 8'h77;
    tick(); tick(); tick();
    n_tests++;
    if (s_wv !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_strobe: got wv=%b expected 1", s_wv);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({s_wv, s_ack0, s_ack1, s_addr, s_wval} !== 19'h0) begin
      n_fail++;
      $display("FAIL rst_mid_strobe: got wv=%b ack=%b%b addr=%h val=%h expected all 0",
               s_wv, s_ack0, s_ack1, s_addr, s_wval);
    end
    req0 = 1'b0;
    seen_ack = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s_ack0 || s_ack1) seen_ack = 1'b1;
    end
    n_tests++;
    if (seen_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_ack: got an ack for the abandoned write expected none");
    end
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'd4; wdata1 = 8'h11;
    tick(); tick(); tick(); tick(); tick(); tick(); tick();
    n_tests++;
    if ({s_ack0, s_ack1, s_err} !== 3'b010) begin
      n_fail++;
      $display("FAIL rst_then_write: got ack0=%b ack1=%b err=%b expected 0 1 0", s_ack0, s_ack1, s_err);
    end
    req1 = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd2;
    tick(); tick(); tick();
    n_tests++;
    if ({s_ack0, s_ack1, s_rdata} !== {2'b10, 8'h41}) begin
      n_fail++;
      $display("FAIL rst_tie_port0: got ack0=%b ack1=%b rdata=%h expected 1 0 41", s_ack0, s_ack1, s_rdata);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_arbitration();
    test_round_robin();
    test_tx_wait();
    test_tx_timeout();
    test_reset_mid_strobe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
